// File: rtl/axis_frame_master.sv
// AXI4-Stream frame transmitter: turns an upstream valid/ready pixel source into
// exactly one WIDTH x HEIGHT frame of beats, tagging frame start (tuser) and line end (tlast).
module axis_frame_master #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int SRC_IMG_WIDTH   = 1920,
  parameter int SRC_IMG_HEIGHT  = 1080,
  parameter int CNT_WIDTH       = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [AXIS_DATA_WIDTH-1:0] pix_data,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_STRB_WIDTH-1:0] m_axis_tstrb,
  output logic [AXIS_STRB_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tid,
  output logic                       m_axis_tdest,
  output logic                       m_axis_tuser,
  output logic                       busy,
  output logic                       frame_done
);

  localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(SRC_IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(SRC_IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       x_q, y_q;
  logic [1:0]                 count_q;
  logic                       wr_ptr_q, rd_ptr_q;
  logic [AXIS_DATA_WIDTH-1:0] buf_data [2];
  logic                       buf_last [2];
  logic                       buf_user [2];

  logic push, pop, pix_last, pix_first, frame_last;

  // Ready depends only on registered state so upstream never sees tready combinationally.
  assign pix_ready  = (state_q == RUN) && (count_q != 2'd2);
  assign push       = pix_valid && pix_ready;
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign pix_last   = (x_q == X_LAST);
  assign pix_first  = (x_q == '0) && (y_q == '0);
  assign frame_last = pix_last && (y_q == Y_LAST);

  assign busy          = (state_q != IDLE);
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? buf_data[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && buf_last[rd_ptr_q];
  assign m_axis_tuser  = m_axis_tvalid && buf_user[rd_ptr_q];
  assign m_axis_tstrb  = '1;
  assign m_axis_tkeep  = '1;
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (push && frame_last) state_d = DRAIN;
      DRAIN: begin
        if (count_q == 2'd0) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        x_q <= '0;
        y_q <= '0;
      end else if (push) begin
        if (pix_last) begin
          x_q <= '0;
          if (!frame_last) y_q <= y_q + CNT_WIDTH'(1);
        end else begin
          x_q <= x_q + CNT_WIDTH'(1);
        end
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer payload carries no reset; visibility is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_q] <= pix_data;
      buf_last[wr_ptr_q] <= pix_last;
      buf_user[wr_ptr_q] <= pix_first;
    end
  end

endmodule
